// File: rtl/shift_exec_unit_if.sv
// Request/result bundle between the execute-stage issue logic and the iterative shift unit.
// master = requester/writeback side, slave = shift unit.
interface shift_exec_unit_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             valid_i;
    logic             ready_o;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] rs1_i;
    logic [WIDTH-1:0] rs2_i;
    logic             kill_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] rd_o;
    logic             busy_o;

    modport master (
        output valid_i, op_i, rs1_i, rs2_i, kill_i, ready_i,
        input  ready_o, valid_o, rd_o, busy_o
    );

    modport slave (
        input  valid_i, op_i, rs1_i, rs2_i, kill_i, ready_i,
        output ready_o, valid_o, rd_o, busy_o
    );

endinterface

// File: rtl/shift_exec_unit.sv
// Iterative SLL/SRL/SRA engine: shifts at most STEP positions per clock, one op in flight,
// result handed to writeback over valid/ready; bit-exact with a single-cycle barrel shifter.
module shift_exec_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4
) (
    input logic             clk_i,
    input logic             rst_ni,
    shift_exec_unit_if.slave bus
);

    localparam int unsigned SW = $clog2(WIDTH);

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    // STEP may equal WIDTH, which needs one more bit than a shift amount.
    localparam logic [SW:0] STEP_W = (SW+1)'(STEP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [SW-1:0]    rem_q;
    logic [SW-1:0]    rem_d;
    logic [1:0]       op_q;
    logic [1:0]       op_d;
    logic             sign_q;
    logic             sign_d;

    logic             accept;
    logic [SW-1:0]    shamt;
    logic [SW-1:0]    step_amt;

    logic             unused_rs2;

    assign accept     = bus.valid_i && (state_q == S_IDLE) && !bus.kill_i;
    assign shamt      = bus.rs2_i[SW-1:0];
    assign unused_rs2 = ^bus.rs2_i[WIDTH-1:SW];

    // Positions to shift this clock: never more than STEP.
    function automatic logic [SW-1:0] clamp_step(input logic [SW-1:0] amt);
        logic [SW-1:0] res;
        if ({1'b0, amt} > STEP_W) begin
            res = SW'(STEP);
        end else begin
            res = amt;
        end
        return res;
    endfunction

    // One partial shift; SRA fills from the sign captured at accept, not from the current MSB.
    function automatic logic [WIDTH-1:0] step_shift(
        input logic [WIDTH-1:0] val,
        input logic [SW-1:0]    amt,
        input logic [1:0]       op,
        input logic             sign
    );
        logic [WIDTH-1:0] fill;
        logic [WIDTH-1:0] res;
        fill = sign ? ~({WIDTH{1'b1}} >> amt) : '0;
        case (op)
            OP_SLL:  res = val << amt;
            OP_SRL:  res = val >> amt;
            OP_SRA:  res = (val >> amt) | fill;
            default: res = val;
        endcase
        return res;
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            op_q    <= OP_SLL;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
        end
    end

    // Datapath update: first step at the accept edge, then one step per clock while busy.
    always_comb begin
        acc_d    = acc_q;
        rem_d    = rem_q;
        op_d     = op_q;
        sign_d   = sign_q;
        step_amt = '0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = bus.op_i;
                    sign_d = bus.rs1_i[WIDTH-1];
                    if (bus.op_i == OP_PASS) begin
                        acc_d = bus.rs1_i;
                        rem_d = '0;
                    end else begin
                        step_amt = clamp_step(shamt);
                        acc_d    = step_shift(bus.rs1_i, step_amt, bus.op_i, bus.rs1_i[WIDTH-1]);
                        rem_d    = shamt - step_amt;
                    end
                end
            end
            S_BUSY: begin
                if (!bus.kill_i) begin
                    step_amt = clamp_step(rem_q);
                    acc_d    = step_shift(acc_q, step_amt, op_q, sign_q);
                    rem_d    = rem_q - step_amt;
                end
            end
            default: ;
        endcase
    end

    // Next state; kill wins over both the result handoff and a new accept.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (rem_d == '0) ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.kill_i) begin
                    state_d = S_IDLE;
                end else if (rem_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.kill_i || bus.ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode registered state only.
    always_comb begin
        bus.ready_o = (state_q == S_IDLE);
        bus.valid_o = (state_q == S_DONE);
        bus.busy_o  = (state_q != S_IDLE);
        bus.rd_o    = acc_q;
    end

endmodule

// File: tb/tb_shift_exec_unit.sv
// Self-checking bench: STEP=1/4/32 shift units driven in lockstep, scoreboard per unit.
module tb_shift_exec_unit;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NDUT  = 3;

    typedef struct {
        logic [31:0] rd;
        int          lat;
        int          acc_cyc;
        logic [1:0]  op;
        logic [4:0]  sh;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            valid;
    logic            kill;
    logic            ready;
    logic [1:0]      op;
    logic [31:0]     rs1;
    logic [31:0]     rs2;

    logic [NDUT-1:0] rdy_v;
    logic [NDUT-1:0] val_v;
    logic [NDUT-1:0] busy_v;
    logic [31:0]     rd_v [NDUT];

    exp_t            sb [NDUT][$];
    int              n_pass  = 0;
    int              n_total = 0;
    int              cyc     = 0;
    bit              rand_ready = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int step_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 4 : 32);
    endfunction

    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] a,
                                              input logic [4:0] sh);
        logic [31:0] r;
        case (o)
            2'b00:   r = a << sh;
            2'b01:   r = a >> sh;
            2'b10:   r = 32'($signed(a) >>> sh);
            default: r = a;
        endcase
        return r;
    endfunction

    function automatic int lat_of(input logic [1:0] o, input logic [4:0] sh, input int st);
        if (o == 2'b11 || sh == 5'd0) return 1;
        return (int'(sh) + st - 1) / st;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    endtask

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        localparam int unsigned STEP_K = step_of(k);

        shift_exec_unit_if #(.WIDTH(WIDTH)) bus ();

        shift_exec_unit #(.WIDTH(WIDTH), .STEP(STEP_K)) dut (
            .clk_i (clk),
            .rst_ni(rst_n),
            .bus   (bus)
        );

        assign bus.valid_i = valid;
        assign bus.op_i    = op;
        assign bus.rs1_i   = rs1;
        assign bus.rs2_i   = rs2;
        assign bus.kill_i  = kill;
        assign bus.ready_i = ready;
        assign rdy_v[k]    = bus.ready_o;
        assign val_v[k]    = bus.valid_o;
        assign busy_v[k]   = bus.busy_o;
        assign rd_v[k]     = bus.rd_o;

        logic prev_valid;

        // Result monitor: latency on the rising edge of valid, data at the handshake.
        always @(negedge clk) begin
            if (!rst_n) begin
                prev_valid <= 1'b0;
            end else begin
                if (val_v[k] && !prev_valid) begin
                    if (sb[k].size() == 0)
                        chk($sformatf("unexpected_valid_dut%0d", k), 32'(sb[k].size()), 32'd1);
                    else
                        chk($sformatf("latency_dut%0d_op%0d_sh%0d", k, sb[k][0].op, sb[k][0].sh),
                            32'(cyc - sb[k][0].acc_cyc + 1), 32'(sb[k][0].lat));
                end
                if (val_v[k] && ready) begin
                    if (sb[k].size() == 0) begin
                        chk($sformatf("unexpected_result_dut%0d", k), 32'(sb[k].size()), 32'd1);
                    end else begin
                        chk($sformatf("rd_dut%0d_op%0d_sh%0d", k, sb[k][0].op, sb[k][0].sh),
                            rd_v[k], sb[k][0].rd);
                        void'(sb[k].pop_front());
                    end
                end
                prev_valid <= val_v[k];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit sb_empty();
        return (sb[0].size() == 0) && (sb[1].size() == 0) && (sb[2].size() == 0);
    endfunction

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!(&rdy_v) && n < 400) begin
            tick();
            if (rand_ready) ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("wait_ready_timeout", 32'(n), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while (!((&rdy_v) && sb_empty()) && n < 400) begin
            tick();
            ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("drain_timeout", 32'(n), 32'd0);
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        wait_ready();
        valid = 1'b1;
        op    = o;
        rs1   = a;
        rs2   = b;
        tick();
        valid = 1'b0;
        op    = 2'($urandom);
        rs1   = $urandom;
        rs2   = $urandom;
        for (int k = 0; k < int'(NDUT); k++)
            sb[k].push_back('{rd: ref_shift(o, a, b[4:0]), lat: lat_of(o, b[4:0], step_of(k)),
                              acc_cyc: cyc, op: o, sh: b[4:0]});
        if (rand_ready) ready = 1'($urandom_range(0, 1));
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int k = 0; k < int'(NDUT); k++) begin
            chk($sformatf("%s_rd_dut%0d", tag, k),    rd_v[k],          32'd0);
            chk($sformatf("%s_valid_dut%0d", tag, k), 32'(val_v[k]),    32'd0);
            chk($sformatf("%s_busy_dut%0d", tag, k),  32'(busy_v[k]),   32'd0);
            chk($sformatf("%s_ready_dut%0d", tag, k), 32'(rdy_v[k]),    32'd1);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        int          n;

        rst_n = 1'b0;
        valid = 1'b0;
        kill  = 1'b0;
        ready = 1'b1;
        op    = 2'b00;
        rs1   = '0;
        rs2   = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        tick();
        rst_n = 1'b1;

        // Directed results; the scoreboard checks data and latency.
        issue(2'b10, 32'h8000_0000, 32'd31);  drain();
        issue(2'b01, 32'h8000_0000, 32'd31);  drain();
        issue(2'b00, 32'h0000_0001, 32'd31);  drain();
        for (int o = 0; o < 4; o++) begin
            issue(2'(o), 32'hDEAD_BEEF, 32'd0);
            drain();
        end
        issue(2'b10, 32'hF000_0000, 32'hFFFF_FFE5);  drain();
        issue(2'b00, 32'hA5A5_A5A5, 32'd4);          drain();
        issue(2'b11, 32'h1357_9BDF, 32'd17);         drain();

        // Backpressure: result must hold and new requests must be ignored.
        tick();
        ready = 1'b0;
        issue(2'b00, 32'h1234_5678, 32'd9);
        n = 0;
        @(negedge clk);
        while (!val_v[1] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", 32'(val_v[1]), 32'd1);
        held = rd_v[1];
        chk("bp_rd_value", held, 32'h68AC_F000);
        for (int i = 0; i < 10; i++) begin
            tick();
            valid = 1'b1;
            op    = 2'($urandom);
            rs1   = $urandom;
            rs2   = $urandom;
            @(negedge clk);
            chk($sformatf("bp_rd_hold_%0d", i),    rd_v[1],        held);
            chk($sformatf("bp_valid_hold_%0d", i), 32'(val_v[1]),  32'd1);
            chk($sformatf("bp_ready_low_%0d", i),  32'(rdy_v[1]),  32'd0);
        end
        tick();
        valid = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_ready_after", 32'(rdy_v[1]), 32'd1);
        chk("bp_busy_after",  32'(busy_v[1]), 32'd0);
        drain();

        // Kill while idle blocks the accept.
        wait_ready();
        valid = 1'b1;
        kill  = 1'b1;
        op    = 2'b00;
        rs1   = 32'h0000_00FF;
        rs2   = 32'd3;
        tick();
        valid = 1'b0;
        kill  = 1'b0;
        @(negedge clk);
        for (int k = 0; k < int'(NDUT); k++) begin
            chk($sformatf("kill_idle_ready_dut%0d", k), 32'(rdy_v[k]),  32'd1);
            chk($sformatf("kill_idle_busy_dut%0d", k),  32'(busy_v[k]), 32'd0);
        end

        // Kill three cycles into a long op; STEP=32 may already be done and is killed in DONE.
        tick();
        ready = 1'b0;
        issue(2'b01, 32'h8000_0000, 32'd31);
        @(posedge clk);
        @(posedge clk);
        #1 kill = 1'b1;
        tick();
        kill = 1'b0;
        for (int k = 0; k < int'(NDUT); k++) sb[k].delete();
        @(negedge clk);
        for (int k = 0; k < int'(NDUT); k++) begin
            chk($sformatf("kill_valid_dut%0d", k), 32'(val_v[k]),  32'd0);
            chk($sformatf("kill_busy_dut%0d", k),  32'(busy_v[k]), 32'd0);
        end
        tick();
        ready = 1'b1;
        repeat (40) @(negedge clk);

        // Reset in the middle of an op.
        tick();
        ready = 1'b0;
        issue(2'b10, 32'h8000_0000, 32'd31);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        for (int k = 0; k < int'(NDUT); k++) sb[k].delete();
        #1 chk_reset_vals("midreset");
        tick();
        rst_n = 1'b1;
        ready = 1'b1;
        repeat (40) @(negedge clk);
        chk_reset_vals("post_reset");

        tick();
        issue(2'b10, 32'h8000_0010, 32'd4);
        drain();

        // Random ops with random result stalls.
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            issue(2'($urandom_range(0, 3)), $urandom, $urandom);
        end
        drain();
        rand_ready = 1'b0;
        tick();
        ready = 1'b1;
        drain();
        chk("sb_empty", 32'(sb[0].size() + sb[1].size() + sb[2].size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/shift_exec_unit.md
Name: shift_exec_unit

Overview:
- Multi-cycle iterative shift engine for the execute stage. Performs SLL, SRL and SRA on register operands and delivers results to writeback through a valid/ready handshake.
- Consumes the same rs1/rs2 operand pair as the single-cycle combinational shifters. Trades latency for area by shifting at most STEP bit positions per clock.
- Holds at most one operation in flight. Its result is bit-exact with a single-cycle barrel shift.

Parameters:
- WIDTH, 32, operand/result width; must be a power of 2; SW = log2(WIDTH).
- STEP, 4, maximum bit positions shifted per clock; power of 2, 1..WIDTH.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- valid_i  in  1  request valid.
- ready_o  out  1  unit can accept a request.
- op_i  in  2  00=SLL, 01=SRL, 10=SRA, 11=pass (rd = rs1).
- rs1_i  in  WIDTH  value to shift.
- rs2_i  in  WIDTH  shift amount source; only rs2_i[SW-1:0] used, upper bits ignored.
- kill_i  in  1  synchronous abort of the in-flight operation (pipeline flush).
- valid_o  out  1  rd_o holds a completed result.
- ready_i  in  1  consumer accepts the result.
- rd_o  out  WIDTH  result.
- busy_o  out  1  high in BUSY or DONE.

Behaviour:
- Reset (rst_ni=0, asynchronous): state=IDLE; rd_o=0, valid_o=0, busy_o=0, ready_o=1; internal operand, remaining-count and op registers cleared.
- States: IDLE, BUSY, DONE. ready_o = (state==IDLE). valid_o = (state==DONE). busy_o = !IDLE.
- Accept: valid_i && ready_o at an edge.
  - shamt = rs2_i[SW-1:0]; sign = rs1_i[WIDTH-1]; op latched.
  - The first step is applied at the accept edge: acc <= rs1_i shifted by s0 = min(shamt, STEP); rem <= shamt - s0.
  - Next state: DONE if rem==0, else BUSY. op=11 forces rem=0 and acc=rs1_i.
- BUSY, each edge: s = min(rem, STEP); acc shifted by s; rem -= s. When the new rem==0, go to DONE.
- Fill rules: SLL and SRL fill with 0. SRA fills with the latched sign bit on every step, not the current acc MSB (identical values; the latched sign is required).
- Latency: valid_o rises max(1, ceil(shamt/STEP)) cycles after the accept edge.
  - WIDTH=32, STEP=4: shamt=0 → 1, shamt=4 → 1, shamt=5 → 2, shamt=31 → 8.
- rd_o = acc. It is stable and valid while in DONE; rd_o content in other states is don't-care for checking.
- DONE: holds until ready_i=1, then returns to IDLE on that edge. No accept occurs in that same cycle (ready_o=0 in DONE); the next accept is earliest one cycle later. Throughput is 1 op per (latency+1) cycles minimum.
- Backpressure: with ready_i=0 in DONE, rd_o and valid_o hold indefinitely. Changes on valid_i, op_i, rs1_i and rs2_i while busy have no effect.
- kill_i=1 at an edge in BUSY or DONE: go to IDLE; valid_o=0 the next cycle; the result is discarded.
  - kill_i in IDLE blocks any accept in that cycle.
  - kill_i has priority over the DONE→IDLE handoff and over accept.
- Reset mid-operation (any state) returns immediately to the reset values. No partial result appears afterwards.
- No combinational path from valid_i or ready_i to any output other than through registered state.

Test Plan:
- SRA, rs1=0x8000_0000, rs2=31, STEP=4 → rd_o=0xFFFF_FFFF; valid_o high exactly 8 cycles after accept.
- SRL, rs1=0x8000_0000, rs2=31 → rd_o=0x0000_0001. SLL, rs1=0x0000_0001, rs2=31 → 0x8000_0000. Both in 8 cycles.
- rs2=0 (any op), rs1=0xDEAD_BEEF → rd_o=0xDEAD_BEEF with valid_o 1 cycle after accept. rs2=0xFFFF_FFE5 (shamt=5), SRA, rs1=0xF000_0000 → 0xFF80_0000 in 2 cycles.
- Backpressure: hold ready_i=0 for 10 cycles in DONE → rd_o/valid_o stable, ready_o=0, new valid_i requests ignored. Then ready_i=1 → IDLE next edge, ready_o=1.
- kill_i pulsed 3 cycles into a shamt=31 op, and rst_ni pulsed low mid-op → valid_o never asserts for that op; next op (SRA 0x8000_0010 >> 4 = 0xF800_0001) completes correctly.
- 1000 random ops with random ready_i stalls, STEP ∈ {1,4,32} → every rd_o matches a reference shift of rs1 by rs2[4:0]; latency matches the formula.
